// File: rtl/carry_lookahead_subtractor.sv
// carry_lookahead_subtractor: two-stage pipelined carry-lookahead i_sub1 - i_sub2 (low half, then high half).
// Latency: 2 cycles from acceptance to o_valid; throughput of one result per cycle.
// Backpressure: valid/ready; o_ready = !s1_valid | s2 can load (i_ready -> o_ready only); buffers up to 2 results.
// Optional macro CLA_SUB_ADD_MODE_EN adds port i_op (1 = add, 0 = subtract), carried per pair.
module carry_lookahead_subtractor #(
  parameter int WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_sub1,
  input  logic [WIDTH-1:0] i_sub2,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH:0]   o_result,
  output logic             o_valid,
  input  logic             i_ready
`ifdef CLA_SUB_ADD_MODE_EN
  ,
  input  logic             i_op
`endif
);

  localparam int LOW  = (WIDTH + 1) / 2;
  localparam int HIGH = WIDTH - LOW;

  // Add-mode select; tied low when the block is built subtract-only.
  logic w_add;
`ifdef CLA_SUB_ADD_MODE_EN
  assign w_add = i_op;
`else
  assign w_add = 1'b0;
`endif

  // Stage 1 state
  logic [LOW-1:0]  r_s1_diff_lo;
  logic            r_s1_carry;
  logic [WIDTH-1:LOW] r_s1_a_hi;
  logic [WIDTH-1:LOW] r_s1_b_hi;   // already conditioned (inverted when subtracting)
  logic            r_s1_add;
  logic            r_s1_valid;

  // Stage 2 (output) state
  logic [WIDTH:0]  r_result;
  logic            r_valid;

  // Handshake
  logic w_s1_load;
  logic w_s2_load;

  assign w_s2_load = r_s1_valid & (~r_valid | i_ready);
  assign o_ready   = ~r_s1_valid | w_s2_load;
  assign w_s1_load = i_valid & o_ready;
  assign o_result  = r_result;
  assign o_valid   = r_valid;

  // Subtraction is a + ~b + 1; addition passes b through with carry-in 0.
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin;
  assign w_b_eff = w_add ? i_sub2 : ~i_sub2;
  assign w_cin   = ~w_add;

  // Low-half lookahead: each carry is expanded from g/p terms, not rippled.
  logic [LOW-1:0] w_g_lo, w_p_lo, w_diff_lo;
  logic [LOW:0]   w_c_lo;
  always_comb begin
    logic w_acc;
    logic w_term;
    w_g_lo    = i_sub1[LOW-1:0] & w_b_eff[LOW-1:0];
    w_p_lo    = i_sub1[LOW-1:0] ^ w_b_eff[LOW-1:0];
    w_c_lo    = '0;
    w_c_lo[0] = w_cin;
    for (int i = 0; i < LOW; i++) begin
      w_acc = w_cin;
      for (int k = 0; k <= i; k++) w_acc = w_acc & w_p_lo[k];
      for (int j = 0; j <= i; j++) begin
        w_term = w_g_lo[j];
        for (int k = j + 1; k <= i; k++) w_term = w_term & w_p_lo[k];
        w_acc = w_acc | w_term;
      end
      w_c_lo[i+1] = w_acc;
    end
    w_diff_lo = w_p_lo ^ w_c_lo[LOW-1:0];
  end

  // High-half lookahead, fed by the registered low-half carry.
  logic [HIGH-1:0] w_g_hi, w_p_hi, w_diff_hi;
  logic [HIGH:0]   w_c_hi;
  always_comb begin
    logic w_acc;
    logic w_term;
    w_g_hi    = r_s1_a_hi & r_s1_b_hi;
    w_p_hi    = r_s1_a_hi ^ r_s1_b_hi;
    w_c_hi    = '0;
    w_c_hi[0] = r_s1_carry;
    for (int i = 0; i < HIGH; i++) begin
      w_acc = r_s1_carry;
      for (int k = 0; k <= i; k++) w_acc = w_acc & w_p_hi[k];
      for (int j = 0; j <= i; j++) begin
        w_term = w_g_hi[j];
        for (int k = j + 1; k <= i; k++) w_term = w_term & w_p_hi[k];
        w_acc = w_acc | w_term;
      end
      w_c_hi[i+1] = w_acc;
    end
    w_diff_hi = w_p_hi ^ w_c_hi[HIGH-1:0];
  end

  // Borrow is the inverted carry-out when subtracting; plain carry-out when adding.
  logic w_msb;
  assign w_msb = r_s1_add ? w_c_hi[HIGH] : ~w_c_hi[HIGH];

  // Stage 1 register: accept a new pair whenever o_ready, drain flag when s1 moves on.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_diff_lo <= '0;
      r_s1_carry   <= 1'b0;
      r_s1_a_hi    <= '0;
      r_s1_b_hi    <= '0;
      r_s1_add     <= 1'b0;
      r_s1_valid   <= 1'b0;
    end else begin
      if (w_s1_load) begin
        r_s1_diff_lo <= w_diff_lo;
        r_s1_carry   <= w_c_lo[LOW];
        r_s1_a_hi    <= i_sub1[WIDTH-1:LOW];
        r_s1_b_hi    <= w_b_eff[WIDTH-1:LOW];
        r_s1_add     <= w_add;
      end
      if (w_s1_load)      r_s1_valid <= 1'b1;
      else if (w_s2_load) r_s1_valid <= 1'b0;
    end
  end

  // Stage 2 register: completes the difference; held stable while the consumer stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (w_s2_load) begin
        r_result <= {w_msb, w_diff_hi, r_s1_diff_lo};
        r_valid  <= 1'b1;
      end else if (i_ready) begin
        r_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: doc/carry_lookahead_subtractor.md
# carry_lookahead_subtractor

Pipelined, handshaked carry-lookahead subtractor: computes i_sub1 − i_sub2 as i_sub1 + ~i_sub2 + 1. The lookahead is split across two registered stages: low half, then high half. It is the subtract-direction counterpart to the team's combinational carry_lookahead_adder. It sits on a valid/ready stream between an operand producer and a result consumer.

## Interface
- WIDTH, 3, operand width in bits; legal range ≥ 2
- i_clk  input  1  clock; all state updates on its rising edge
- i_rst  input  1  reset; synchronous, active-high
- i_sub1  input  WIDTH  minuend, unsigned
- i_sub2  input  WIDTH  subtrahend, unsigned
- i_valid  input  1  operand pair present
- o_ready  output  1  block accepts the operand pair this cycle
- o_result  output  WIDTH+1  difference, two's complement; bit WIDTH is the borrow/sign
- o_valid  output  1  o_result holds a completed difference
- i_ready  input  1  consumer accepts o_result this cycle

## Operation
- Split: LOW = (WIDTH+1)/2 bits in stage 1, HIGH = WIDTH−LOW bits in stage 2.
- Carry logic: both halves use generate/propagate lookahead (g = a & ~b, p = a ^ ~b). Carry-in to stage 1 is 1.
- Stage 1 register (s1): holds
  - low difference bits
  - low-half carry-out
  - high halves of the operands
  - s1_valid
- Stage 2 register (s2, the output register): holds the full WIDTH-bit difference and the borrow. The borrow is the inverted final carry-out.
- o_result = {~carry_out, diff}. This equals (i_sub1 − i_sub2) mod 2^(WIDTH+1), so it is the exact signed difference.
- Advance rules:
  - s2 loads when s1_valid and (!o_valid or i_ready).
  - s1 loads when i_valid and o_ready.
  - s1_valid clears when s1 drains into s2 and no new pair is accepted.
- o_ready = !s1_valid or s2 load condition. This is combinational, with no dependence on i_valid.
- Output transfer occurs when o_valid and i_ready.
- o_valid clears on transfer unless s2 reloads in the same cycle.
- Simultaneous accept and drain: s1 captures the new pair while its old contents move to s2. There is no bubble.
- While o_valid is high and i_ready is low:
  - o_result is held stable.
  - At most one further pair is buffered in s1.
- Operand pairs are never dropped, duplicated or reordered.
- Reset values: s1_valid=0, o_valid=0, o_result=0, all data registers 0. o_ready=1 on the first cycle after reset deasserts.
- Reset mid-operation: any in-flight pairs are discarded. Handshake inputs are ignored while i_rst is high.

## Timing
- Latency: a pair accepted at edge N appears on o_result with o_valid=1 after edge N+1. That is 2 cycles of register depth.
- Throughput: one result per cycle while i_ready=1.
- Stall: the pipeline holds up to 2 results. o_ready falls in the cycle where both s1 and s2 are full and i_ready=0.
- Combinational path: i_ready → o_ready only. There is no path from i_valid to o_ready.

## Configuration
- CLA_SUB_ADD_MODE_EN defined:
  - Adds port i_op (input, 1 bit), sampled with the operands and carried through s1.
  - i_op=1 selects add: operand b is not inverted and the stage-1 carry-in is 0.
  - In add mode, o_result = {carry_out, sum}, the unsigned sum. This matches the combinational adder's output format.
  - i_op=0 selects subtract.
- CLA_SUB_ADD_MODE_EN undefined: port i_op is absent and the block always subtracts.

## Test plan
- WIDTH=3, 5−2 with i_ready=1 → o_result=4'b0011, o_valid exactly 2 edges after acceptance.
- 2−5 → 4'b1101 (−3). 0−7 → 4'b1001 (−7). 7−7 → 4'b0000. 7−0 → 4'b0111. Results are issued back-to-back, one per cycle, in order.
- Backpressure:
  - Issue 1−0, 2−0, 3−0 on consecutive cycles with i_ready=0.
  - o_ready goes 0 after two accepts, and o_result is held at 4'b0001.
  - Release i_ready: results arrive in order 1, 2, 3 with no loss.
- Simultaneous events: with o_valid=1, s1 full and i_ready=1, present a new pair → accept, drain and output all occur in the same cycle, and the sequence matches a reference model.
- Reset mid-operation: assert i_rst for 1 cycle with 2 pairs in flight → o_valid=0 and o_result=0 after the edge, o_ready=1 next cycle, no stale results emitted.
- CLA_SUB_ADD_MODE_EN defined: 7+7 (i_op=1) → 4'b1110; then 3−6 (i_op=0) → 4'b1101. Interleaved ops keep per-pair mode.
- Randomized sweep of all 64 operand pairs with random i_valid/i_ready → every result matches a − b and ordering is preserved.
